// File: rtl/round_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : round_sequencer_if
// Purpose  : Game-flow bus between the round sequencer and its surroundings.
// Revision : 1.0
// ============================================================================
interface round_sequencer_if;
  logic        start;
  logic        button;
  logic        match;
  logic [1:0]  life;
  logic        en;
  logic [1:0]  level;
  logic        disp;
  logic [8:0]  seq1;
  logic [15:0] seq2;
  logic [24:0] seq3;
  logic        game_over;
  logic [7:0]  round_cnt;

  modport master (
    input  start, button, match, life,
    output en, level, disp, seq1, seq2, seq3, game_over, round_cnt
  );

  modport slave (
    output start, button, match, life,
    input  en, level, disp, seq1, seq2, seq3, game_over, round_cnt
  );
endinterface
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : round_sequencer
// Purpose  : Memory-game flow: pattern generation, show/input timing, judging.
// Revision : 1.0
// ============================================================================
module round_sequencer #(
  parameter int unsigned DISP_CYCLES    = 200000000,
  parameter int unsigned INPUT_CYCLES   = 500000000,
  parameter int unsigned WINS_PER_LEVEL = 3,
  parameter logic [24:0] SEED           = 25'h1ACE5
) (
  input  logic              clk,
  input  logic              reset,
  round_sequencer_if.master bus
);

  localparam int unsigned C_MAX_CYCLES =
    (DISP_CYCLES > INPUT_CYCLES) ? DISP_CYCLES : INPUT_CYCLES;
  localparam int C_TW = $clog2(C_MAX_CYCLES + 1);
  localparam int C_WW = $clog2(WINS_PER_LEVEL + 1);
  localparam logic [C_TW-1:0] C_DISP_LAST  = C_TW'(DISP_CYCLES - 1);
  localparam logic [C_TW-1:0] C_INPUT_LAST = C_TW'(INPUT_CYCLES - 1);
  localparam logic [C_WW-1:0] C_WINS       = C_WW'(WINS_PER_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_SHOW  = 3'd2,
    S_INPUT = 3'd3,
    S_JUDGE = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t            r_state;
  logic [24:0]       r_lfsr;
  logic [C_TW-1:0]   r_timer;
  logic [C_WW-1:0]   r_win_cnt;
  logic              r_pass;
  logic              r_en;
  logic              r_disp;
  logic [1:0]        r_level;
  logic [8:0]        r_seq1;
  logic [15:0]       r_seq2;
  logic [24:0]       r_seq3;
  logic              r_game_over;
  logic [7:0]        r_round_cnt;

  logic [24:0]       w_lfsr_next;
  logic [C_WW-1:0]   w_win_inc;

  // x^25 + x^22 + 1, shifting left
  assign w_lfsr_next = {r_lfsr[23:0], r_lfsr[24] ^ r_lfsr[21]};
  assign w_win_inc   = r_win_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED;
      r_timer     <= '0;
      r_win_cnt   <= '0;
      r_pass      <= 1'b0;
      r_en        <= 1'b0;
      r_disp      <= 1'b0;
      r_level     <= 2'd0;
      r_seq1      <= '0;
      r_seq2      <= '0;
      r_seq3      <= '0;
      r_game_over <= 1'b0;
      r_round_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_GEN;
        end
        S_GEN: begin
          r_lfsr <= w_lfsr_next;
          // An all-dark pattern is unplayable, so light cell 0 instead.
          case (r_level)
            2'd0:    r_seq1 <= (w_lfsr_next[8:0] == '0)  ? 9'd1  : w_lfsr_next[8:0];
            2'd1:    r_seq2 <= (w_lfsr_next[15:0] == '0) ? 16'd1 : w_lfsr_next[15:0];
            default: r_seq3 <= (w_lfsr_next == '0)       ? 25'd1 : w_lfsr_next;
          endcase
          r_timer <= '0;
          r_disp  <= 1'b1;
          r_state <= S_SHOW;
        end
        S_SHOW: begin
          if (r_timer == C_DISP_LAST) begin
            r_timer <= '0;
            r_disp  <= 1'b0;
            r_en    <= 1'b1;
            r_state <= S_INPUT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_INPUT: begin
          // A submit on the final window cycle still counts.
          if (bus.button) begin
            r_pass  <= bus.match;
            r_en    <= 1'b0;
            r_state <= S_JUDGE;
          end else if (r_timer == C_INPUT_LAST) begin
            r_pass  <= 1'b0;
            r_en    <= 1'b0;
            r_state <= S_JUDGE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_JUDGE: begin
          if (r_round_cnt != 8'hFF) r_round_cnt <= r_round_cnt + 8'd1;
          if (r_pass && (bus.life != 2'd0)) begin
            if (w_win_inc == C_WINS) begin
              r_win_cnt <= '0;
              if (r_level != 2'd2) r_level <= r_level + 2'd1;
            end else begin
              r_win_cnt <= w_win_inc;
            end
            r_state <= S_GEN;
          end else begin
            r_win_cnt <= '0;
            if (bus.life <= 2'd1) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_GEN;
            end
          end
        end
        S_OVER: begin
          if (bus.start) begin
            r_level     <= 2'd0;
            r_win_cnt   <= '0;
            r_round_cnt <= 8'd0;
            r_game_over <= 1'b0;
            r_state     <= S_GEN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.en        = r_en;
  assign bus.disp      = r_disp;
  assign bus.level     = r_level;
  assign bus.seq1      = r_seq1;
  assign bus.seq2      = r_seq2;
  assign bus.seq3      = r_seq3;
  assign bus.game_over = r_game_over;
  assign bus.round_cnt = r_round_cnt;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_round_sequencer
// Purpose  : Randomised round-level bench for round_sequencer.
// Revision : 1.0
// ============================================================================
module tb_round_sequencer;

  localparam int          DISP = 4;
  localparam int          INP  = 8;
  localparam int          WINS = 2;
  localparam logic [24:0] SEED = 25'h1ACE5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  round_sequencer_if bus ();

  round_sequencer #(
    .DISP_CYCLES    (DISP),
    .INPUT_CYCLES   (INP),
    .WINS_PER_LEVEL (WINS),
    .SEED           (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic        e_en, e_disp, e_go;
  logic [1:0]  e_level;
  logic [8:0]  e_seq1;
  logic [15:0] e_seq2;
  logic [24:0] e_seq3;
  logic [7:0]  e_rc;

  // Game model
  logic [24:0] m_lfsr;
  int          m_level, m_wins, m_round;
  bit          m_over;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("en",        32'(bus.en),        32'(e_en));
      check("disp",      32'(bus.disp),      32'(e_disp));
      check("level",     32'(bus.level),     32'(e_level));
      check("seq1",      32'(bus.seq1),      32'(e_seq1));
      check("seq2",      32'(bus.seq2),      32'(e_seq2));
      check("seq3",      32'(bus.seq3),      32'(e_seq3));
      check("game_over", 32'(bus.game_over), 32'(e_go));
      check("round_cnt", 32'(bus.round_cnt), 32'(e_rc));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] lfsr_step(input logic [24:0] x);
    return {x[23:0], x[24] ^ x[21]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.start  = 1'($urandom_range(0, 1));
    bus.button = 1'($urandom_range(0, 1));
    bus.match  = 1'($urandom_range(0, 1));
    bus.life   = 2'($urandom_range(0, 3));
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_level = 0; m_wins = 0; m_round = 0; m_over = 0;
    e_en = 0; e_disp = 0; e_go = 0; e_level = 0;
    e_seq1 = '0; e_seq2 = '0; e_seq3 = '0; e_rc = '0;
  endtask

  task automatic model_gen();
    logic [24:0] v;
    m_lfsr = lfsr_step(m_lfsr);
    v = m_lfsr;
    case (m_level)
      0:       begin e_seq1 = v[8:0];  if (e_seq1 == 0) e_seq1 = 9'd1;  end
      1:       begin e_seq2 = v[15:0]; if (e_seq2 == 0) e_seq2 = 16'd1; end
      default: begin e_seq3 = v;       if (e_seq3 == 0) e_seq3 = 25'd1; end
    endcase
  endtask

  // Entered on the GEN cycle; returns on the following GEN or OVER cycle.
  // bc = INPUT cycle (1..INP) carrying the button, 0 for a timeout.
  task automatic play_round(input int bc, input bit mt, input logic [1:0] lf);
    bit pass = 0;
    noise();
    tick();
    model_gen();
    e_disp = 1;
    for (int i = 0; i < DISP; i++) begin
      if (i > 0) tick();
      noise();
      bus.button = 1'($urandom_range(0, 1));
    end
    tick();
    e_disp = 0; e_en = 1;
    for (int i = 1; i <= INP; i++) begin
      if (i > 1) tick();
      noise();
      bus.button = (i == bc);
      if (i == bc) begin
        bus.match = mt;
        pass = mt;
        break;
      end
    end
    tick();
    e_en = 0;
    noise();
    bus.life = lf;
    if (m_round < 255) m_round++;
    if (pass && lf != 0) begin
      m_wins++;
      if (m_wins == WINS) begin
        m_wins = 0;
        if (m_level < 2) m_level++;
      end
    end else begin
      m_wins = 0;
      if (lf <= 1) m_over = 1;
    end
    tick();
    bus.start = 0; bus.button = 0;
    e_rc = 8'(m_round); e_level = 2'(m_level); e_go = m_over;
  endtask

  task automatic over_wait(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      bus.start = 0;
      tick();
    end
  endtask

  task automatic restart();
    noise();
    bus.start = 1;
    tick();
    bus.start = 0;
    m_level = 0; m_wins = 0; m_round = 0; m_over = 0;
    e_level = 0; e_rc = 0; e_go = 0;
  endtask

  initial begin
    bus.start = 0; bus.button = 0; bus.match = 0; bus.life = 2'd3;
    reset = 1;
    model_reset();
    tick();
    chk_en = 1;
    tick();
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_round_cnt", 32'(bus.round_cnt), 32'd0);
    reset = 0;

    // IDLE ignores button/match
    over_wait(3);
    bus.start = 1;
    tick();
    bus.start = 0;

    play_round($urandom_range(1, INP), 1, 3);
    check("seq1_first_gen", 32'(bus.seq1), 32'h1CA);
    play_round($urandom_range(1, INP), 1, 3);
    check("level_after_2_wins", 32'(bus.level), 32'd1);
    play_round($urandom_range(1, INP), 1, 3);
    check("seq2_first_load", 32'(bus.seq2), 32'h6728);
    play_round($urandom_range(1, INP), 1, 3);
    check("level_after_4_wins", 32'(bus.level), 32'd2);
    check("round_cnt_after_4", 32'(bus.round_cnt), 32'd4);
    play_round($urandom_range(1, INP), 1, 3);
    play_round($urandom_range(1, INP), 1, 3);
    check("level_holds_at_2", 32'(bus.level), 32'd2);

    play_round(0, 1, 2'd2);
    check("timeout_life2_continues", 32'(bus.game_over), 32'd0);
    play_round(0, 1, 2'd1);
    check("timeout_life1_over", 32'(bus.game_over), 32'd1);
    over_wait(3);
    restart();
    check("restart_level", 32'(bus.level), 32'd0);
    check("restart_round_cnt", 32'(bus.round_cnt), 32'd0);

    play_round(INP, 1, 3);
    play_round(INP, 1, 3);
    check("last_cycle_button_passes", 32'(bus.level), 32'd1);

    for (int r = 0; r < 40; r++) begin
      logic [1:0] lf;
      if (m_over) begin
        over_wait($urandom_range(0, 3));
        restart();
      end
      lf = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      play_round($urandom_range(0, INP), 1'($urandom_range(0, 1)), lf);
    end
    if (m_over) begin
      over_wait(1);
      restart();
    end

    for (int r = 0; r < 260; r++)
      play_round($urandom_range(0, INP), 1'($urandom_range(0, 1)), 2'd3);
    check("round_cnt_saturates", 32'(bus.round_cnt), 32'd255);

    // Asynchronous reset in the middle of SHOW
    noise();
    tick();
    model_gen();
    e_disp = 1;
    noise();
    tick();
    #2;
    reset = 1;
    model_reset();
    #1;
    check("async_rst_disp", 32'(bus.disp), 32'd0);
    check("async_rst_level", 32'(bus.level), 32'd0);
    check("async_rst_seq1", 32'(bus.seq1), 32'd0);
    tick();
    tick();
    reset = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    play_round($urandom_range(1, INP), 1, 3);
    check("seq1_after_reset_regen", 32'(bus.seq1), 32'h1CA);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
